// File: rtl/ttt_pkg.sv
// Shared encodings for the TTT core sequencer: core instruction set,
// sequencer FSM states and the token start/stop codes.
package ttt_pkg;

    typedef enum logic [2:0] {
        TTT_NOP       = 3'b000,
        TTT_ACCUM     = 3'b001,
        TTT_STEP      = 3'b010,
        TTT_PROG_DUR  = 3'b101,
        TTT_PROG_GOOD = 3'b110,
        TTT_PROG_BAD  = 3'b111
    } ttt_instr_t;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_PROG  = 3'd2,
        ST_UPD   = 3'd3,
        ST_STEP  = 3'd4,
        ST_DRAIN = 3'd5
    } seq_state_t;

    localparam logic [1:0] SS_START = 2'b10;
    localparam logic [1:0] SS_STOP  = 2'b01;

    // True for the three host-programmable instructions
    function automatic logic is_prog_instr(input logic [2:0] instr);
        return (instr == TTT_PROG_DUR) || (instr == TTT_PROG_GOOD) || (instr == TTT_PROG_BAD);
    endfunction

endpackage

// File: rtl/ttt_event_capture.sv
// Tags the core's registered token_startstop with the processor that just
// stepped. The core output only means something in the cycle right after a
// STEP; at all other times it holds a stale value and is ignored.
module ttt_event_capture
    import ttt_pkg::*;
#(
    parameter int ID_W = 4
)(
    input  logic            clock_fast,
    input  logic            reset,
    input  logic            step,
    input  logic [ID_W-1:0] id,
    input  logic [1:0]      core_startstop,
    output logic            event_valid,
    output logic [ID_W-1:0] event_id,
    output logic            event_start
);

    logic            step_reg;
    logic [ID_W-1:0] id_reg;

    // Delay the step marker and its id by one cycle to line up with the core result
    always_ff @(posedge clock_fast) begin
        if (reset) begin
            step_reg <= 1'b0;
            id_reg   <= '0;
        end else begin
            step_reg <= step;
            id_reg   <= id;
        end
    end

    // Decode start/stop only in the sampling cycle; 00 and 11 carry no event
    always_comb begin
        event_valid = 1'b0;
        event_start = 1'b0;
        event_id    = id_reg;
        if (step_reg) begin
            if (core_startstop == SS_START) begin
                event_valid = 1'b1;
                event_start = 1'b1;
            end else if (core_startstop == SS_STOP) begin
                event_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ttt_core_sequencer.sv
// Time-multiplexing controller for the shared TTT core: init sweep after
// reset, single-cycle host programming, and uninterruptible update sweeps
// (ACCUM/STEP per processor) with a divided clock_slow marker.
module ttt_core_sequencer
    import ttt_pkg::*;
#(
    parameter int NUM_PROCESSORS = 10,
    parameter int DURATION_BITS  = 8,
    parameter int TOKEN_BITS     = 8,
    parameter int SLOW_DIV       = 4,
    localparam int ID_W = (NUM_PROCESSORS > 1) ? $clog2(NUM_PROCESSORS) : 1
)(
    input  logic                     clock_fast,
    input  logic                     reset,
    input  logic                     run_enable,
    input  logic                     prog_valid,
    output logic                     prog_ready,
    input  logic [2:0]               prog_instr,
    input  logic [ID_W-1:0]          prog_id,
    input  logic [DURATION_BITS-1:0] prog_duration_in,
    input  logic [TOKEN_BITS-1:0]    prog_threshold_in,
    output logic                     core_reset,
    output logic [ID_W-1:0]          core_id,
    output logic [2:0]               core_instr,
    output logic                     core_slow,
    output logic [DURATION_BITS-1:0] core_duration,
    output logic [TOKEN_BITS-1:0]    core_threshold,
    input  logic [1:0]               core_startstop,
    output logic                     event_valid,
    output logic [ID_W-1:0]          event_id,
    output logic                     event_start,
    output logic                     sweep_done,
    output logic                     init_done
);

    localparam int SW_W = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
    localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_PROCESSORS - 1);
    localparam logic [SW_W-1:0] SLOW_LAST = SW_W'(SLOW_DIV - 1);

    seq_state_t         state_reg, state_next;
    logic [ID_W-1:0]    id_reg, id_next;
    logic [SW_W-1:0]    sweep_reg, sweep_next;
    logic               load_prog;
    logic               slow_sweep;

    logic [2:0]               prog_instr_reg;
    logic [ID_W-1:0]          prog_id_reg;
    logic                     prog_ok_reg;
    logic [DURATION_BITS-1:0] duration_reg;
    logic [TOKEN_BITS-1:0]    threshold_reg;

    assign slow_sweep     = (sweep_reg == SLOW_LAST);
    assign init_done      = (state_reg != ST_INIT);
    assign core_duration  = duration_reg;
    assign core_threshold = threshold_reg;

    // FSM state, processor index and sweep divider
    always_ff @(posedge clock_fast) begin
        if (reset) begin
            state_reg <= ST_INIT;
            id_reg    <= '0;
            sweep_reg <= '0;
        end else begin
            state_reg <= state_next;
            id_reg    <= id_next;
            sweep_reg <= sweep_next;
        end
    end

    // Latch an accepted host request; bad opcodes or ids are kept but flagged as no-ops
    always_ff @(posedge clock_fast) begin
        if (reset) begin
            prog_instr_reg <= 3'b000;
            prog_id_reg    <= '0;
            prog_ok_reg    <= 1'b0;
            duration_reg   <= '0;
            threshold_reg  <= '0;
        end else if (load_prog) begin
            prog_instr_reg <= prog_instr;
            prog_id_reg    <= prog_id;
            prog_ok_reg    <= is_prog_instr(prog_instr) && (int'(prog_id) < NUM_PROCESSORS);
            duration_reg   <= prog_duration_in;
            threshold_reg  <= prog_threshold_in;
        end
    end

    // Next-state logic and core drive; programming wins over starting a sweep
    always_comb begin
        state_next = state_reg;
        id_next    = id_reg;
        sweep_next = sweep_reg;
        load_prog  = 1'b0;
        core_instr = TTT_NOP;
        core_id    = id_reg;
        core_reset = 1'b0;
        core_slow  = 1'b0;
        prog_ready = 1'b0;
        sweep_done = 1'b0;
        case (state_reg)
            ST_INIT: begin
                core_reset = 1'b1;
                if (id_reg == LAST_ID) begin
                    state_next = ST_IDLE;
                    id_next    = '0;
                end else begin
                    id_next = id_reg + 1'b1;
                end
            end
            ST_IDLE: begin
                prog_ready = 1'b1;
                if (prog_valid) begin
                    load_prog  = 1'b1;
                    state_next = ST_PROG;
                end else if (run_enable) begin
                    state_next = ST_UPD;
                    id_next    = '0;
                end
            end
            ST_PROG: begin
                core_instr = prog_ok_reg ? prog_instr_reg : TTT_NOP;
                core_id    = prog_id_reg;
                state_next = ST_IDLE;
            end
            ST_UPD: begin
                core_instr = TTT_ACCUM;
                core_slow  = slow_sweep;
                state_next = ST_STEP;
            end
            ST_STEP: begin
                core_instr = TTT_STEP;
                core_slow  = slow_sweep;
                if (id_reg == LAST_ID) begin
                    state_next = ST_DRAIN;
                end else begin
                    state_next = ST_UPD;
                    id_next    = id_reg + 1'b1;
                end
            end
            ST_DRAIN: begin
                sweep_done = 1'b1;
                sweep_next = slow_sweep ? '0 : sweep_reg + 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_INIT;
                id_next    = '0;
            end
        endcase
    end

    ttt_event_capture #(
        .ID_W(ID_W)
    ) u_event_capture (
        .clock_fast     (clock_fast),
        .reset          (reset),
        .step           (state_reg == ST_STEP),
        .id             (id_reg),
        .core_startstop (core_startstop),
        .event_valid    (event_valid),
        .event_id       (event_id),
        .event_start    (event_start)
    );

endmodule

// File: tb/tb_ttt_core_sequencer.sv
// Directed bench for ttt_core_sequencer with a tiny core stand-in that
// registers a per-processor start/stop code on each STEP edge.
module tb_ttt_core_sequencer;

    localparam int N    = 10;
    localparam int ID_W = 4;

    logic             clock_fast = 1'b0;
    logic             reset = 1'b1;
    logic             run_enable = 1'b0;
    logic             prog_valid = 1'b0;
    logic             prog_ready;
    logic [2:0]       prog_instr = 3'b000;
    logic [ID_W-1:0]  prog_id = '0;
    logic [7:0]       prog_duration_in = 8'h00;
    logic [7:0]       prog_threshold_in = 8'h00;
    logic             core_reset;
    logic [ID_W-1:0]  core_id;
    logic [2:0]       core_instr;
    logic             core_slow;
    logic [7:0]       core_duration;
    logic [7:0]       core_threshold;
    logic [1:0]       core_startstop = 2'b00;
    logic             event_valid;
    logic [ID_W-1:0]  event_id;
    logic             event_start;
    logic             sweep_done;
    logic             init_done;

    logic [1:0] plan [0:15];
    int checks = 0;
    int failures = 0;
    int sweep_count = 0;

    ttt_core_sequencer dut (
        .clock_fast        (clock_fast),
        .reset             (reset),
        .run_enable        (run_enable),
        .prog_valid        (prog_valid),
        .prog_ready        (prog_ready),
        .prog_instr        (prog_instr),
        .prog_id           (prog_id),
        .prog_duration_in  (prog_duration_in),
        .prog_threshold_in (prog_threshold_in),
        .core_reset        (core_reset),
        .core_id           (core_id),
        .core_instr        (core_instr),
        .core_slow         (core_slow),
        .core_duration     (core_duration),
        .core_threshold    (core_threshold),
        .core_startstop    (core_startstop),
        .event_valid       (event_valid),
        .event_id          (event_id),
        .event_start       (event_start),
        .sweep_done        (sweep_done),
        .init_done         (init_done)
    );

    always #5 clock_fast = ~clock_fast;

    // Core stand-in: token_startstop is registered on the STEP edge and then held
    always @(posedge clock_fast) begin
        if (core_instr == 3'b010)
            core_startstop <= plan[core_id];
    end

    task automatic cyc();
        @(negedge clock_fast);
    endtask

    // One full update sweep, entered at the UPD(0) cycle, left at the following IDLE cycle
    task automatic do_sweep();
        logic       exp_slow;
        logic [1:0] p;
        exp_slow = ((sweep_count % 4) == 3);
        for (int i = 0; i <= N; i++) begin
            // head cycle: UPD(i) or DRAIN, carrying the event of processor i-1
            if (i == 0) begin
                checks++;
                if (event_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL sweep_first_no_event got=%b want=0", event_valid);
                end
            end else begin
                p = plan[i-1];
                checks++;
                if (event_valid !== (p == 2'b10 || p == 2'b01)) begin
                    failures++;
                    $display("FAIL event_valid id=%0d got=%b want=%b", i-1, event_valid, (p == 2'b10 || p == 2'b01));
                end
                if (p == 2'b10 || p == 2'b01) begin
                    checks++;
                    if (event_id !== 4'(i-1) || event_start !== (p == 2'b10)) begin
                        failures++;
                        $display("FAIL event_tag got id=%0d start=%b want id=%0d start=%b", event_id, event_start, i-1, (p == 2'b10));
                    end
                end
            end
            if (i < N) begin
                checks++;
                if (core_instr !== 3'b001 || core_id !== 4'(i) || prog_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL upd got instr=%b id=%0d ready=%b want 001 id=%0d ready=0", core_instr, core_id, prog_ready, i);
                end
                checks++;
                if (core_slow !== exp_slow) begin
                    failures++;
                    $display("FAIL slow_upd sweep=%0d id=%0d got=%b want=%b", sweep_count, i, core_slow, exp_slow);
                end
                cyc();
                checks++;
                if (core_instr !== 3'b010 || core_id !== 4'(i) || core_slow !== exp_slow || event_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL step got instr=%b id=%0d slow=%b ev=%b want 010 id=%0d slow=%b ev=0", core_instr, core_id, core_slow, event_valid, i, exp_slow);
                end
            end else begin
                checks++;
                if (core_instr !== 3'b000 || sweep_done !== 1'b1 || core_slow !== 1'b0) begin
                    failures++;
                    $display("FAIL drain got instr=%b done=%b slow=%b want 000 1 0", core_instr, sweep_done, core_slow);
                end
            end
            cyc();
        end
        // back in IDLE: stale core output must not produce an event
        checks++;
        if (core_instr !== 3'b000 || sweep_done !== 1'b0 || event_valid !== 1'b0 || prog_ready !== 1'b1) begin
            failures++;
            $display("FAIL idle_after_sweep got instr=%b done=%b ev=%b ready=%b", core_instr, sweep_done, event_valid, prog_ready);
        end
        $display("sweep %0d done slow=%b", sweep_count, exp_slow);
        sweep_count++;
    endtask

    // n back-to-back sweeps from IDLE, ending in IDLE with run_enable low
    task automatic run_sweeps(input int n);
        run_enable = 1'b1;
        cyc();
        for (int s = 0; s < n; s++) begin
            do_sweep();
            if (s == n - 1) run_enable = 1'b0;
            else cyc();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc();
        cyc();
        checks++;
        if (core_reset !== 1'b1 || core_id !== 4'd0 || core_instr !== 3'b000 || core_slow !== 1'b0 ||
            event_valid !== 1'b0 || sweep_done !== 1'b0 || prog_ready !== 1'b0 || init_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got rst=%b id=%0d instr=%b slow=%b ev=%b done=%b ready=%b init=%b",
                     core_reset, core_id, core_instr, core_slow, event_valid, sweep_done, prog_ready, init_done);
        end
        reset = 1'b0;
        for (int k = 0; k < N; k++) begin
            checks++;
            if (core_reset !== 1'b1 || core_id !== 4'(k) || init_done !== 1'b0) begin
                failures++;
                $display("FAIL init_step k=%0d got rst=%b id=%0d init=%b", k, core_reset, core_id, init_done);
            end
            cyc();
        end
        checks++;
        if (init_done !== 1'b1 || prog_ready !== 1'b1 || core_instr !== 3'b000 || core_reset !== 1'b0) begin
            failures++;
            $display("FAIL init_end got init=%b ready=%b instr=%b rst=%b want 1 1 000 0", init_done, prog_ready, core_instr, core_reset);
        end
        $display("reset/init sequence complete");
    endtask

    task automatic test_prog();
        prog_valid = 1'b1;
        prog_instr = 3'b110;
        prog_id = 4'd3;
        prog_threshold_in = 8'd5;
        prog_duration_in = 8'h3C;
        run_enable = 1'b1;
        cyc();
        checks++;
        if (core_instr !== 3'b110 || core_id !== 4'd3 || core_threshold !== 8'd5 || core_duration !== 8'h3C || prog_ready !== 1'b0) begin
            failures++;
            $display("FAIL prog_cycle got instr=%b id=%0d thr=%0d dur=%h ready=%b want 110 3 5 3c 0",
                     core_instr, core_id, core_threshold, core_duration, prog_ready);
        end
        prog_valid = 1'b0;
        cyc();
        checks++;
        if (core_instr !== 3'b000 || prog_ready !== 1'b1) begin
            failures++;
            $display("FAIL prog_return got instr=%b ready=%b want 000 1", core_instr, prog_ready);
        end
        cyc();
        run_enable = 1'b0;
        checks++;
        if (core_instr !== 3'b001 || core_id !== 4'd0) begin
            failures++;
            $display("FAIL sweep_after_prog got instr=%b id=%0d want 001 0", core_instr, core_id);
        end
        $display("prog 110 id=3 thr=5 accepted, sweep follows");
        do_sweep();
    endtask

    task automatic test_slow_back_to_back();
        run_sweeps(5);
    endtask

    task automatic test_events();
        plan[3] = 2'b10;
        plan[9] = 2'b10;
        run_sweeps(1);
        // linger in IDLE with a stale 2'b10 on the core output
        plan[3] = 2'b01;
        plan[9] = 2'b00;
        cyc();
        checks++;
        if (event_valid !== 1'b0 || core_startstop !== 2'b10) begin
            failures++;
            $display("FAIL stale_idle got ev=%b ss=%b want ev=0 ss=10", event_valid, core_startstop);
        end
        run_sweeps(1);
        plan[3] = 2'b00;
        $display("event sweeps complete");
    endtask

    task automatic test_drop();
        prog_valid = 1'b1;
        prog_instr = 3'b110;
        prog_id = 4'd12;
        checks++;
        if (prog_ready !== 1'b1) begin
            failures++;
            $display("FAIL drop_ready got=%b want=1", prog_ready);
        end
        cyc();
        checks++;
        if (core_instr !== 3'b000 || prog_ready !== 1'b0) begin
            failures++;
            $display("FAIL drop_bad_id got instr=%b ready=%b want 000 0", core_instr, prog_ready);
        end
        prog_instr = 3'b011;
        prog_id = 4'd2;
        cyc();
        checks++;
        if (prog_ready !== 1'b1) begin
            failures++;
            $display("FAIL drop_throughput got ready=%b want=1", prog_ready);
        end
        cyc();
        checks++;
        if (core_instr !== 3'b000) begin
            failures++;
            $display("FAIL drop_bad_instr got instr=%b want 000", core_instr);
        end
        prog_instr = 3'b101;
        prog_id = 4'd9;
        prog_duration_in = 8'd1;
        cyc();
        cyc();
        checks++;
        if (core_instr !== 3'b101 || core_id !== 4'd9 || core_duration !== 8'd1) begin
            failures++;
            $display("FAIL prog_dur_last got instr=%b id=%0d dur=%0d want 101 9 1", core_instr, core_id, core_duration);
        end
        prog_valid = 1'b0;
        cyc();
        checks++;
        if (core_instr !== 3'b000 || prog_ready !== 1'b1) begin
            failures++;
            $display("FAIL prog_idle got instr=%b ready=%b want 000 1", core_instr, prog_ready);
        end
        $display("prog drops (id=12, instr=011) and 101 id=9 done");
    endtask

    task automatic test_abort();
        run_sweeps(1);
        plan[5] = 2'b10;
        run_enable = 1'b1;
        cyc();
        run_enable = 1'b0;
        repeat (11) cyc();
        checks++;
        if (core_instr !== 3'b010 || core_id !== 4'd5) begin
            failures++;
            $display("FAIL abort_reach got instr=%b id=%0d want 010 5", core_instr, core_id);
        end
        reset = 1'b1;
        cyc();
        checks++;
        if (event_valid !== 1'b0 || core_reset !== 1'b1 || core_id !== 4'd0 || core_instr !== 3'b000 ||
            init_done !== 1'b0 || prog_ready !== 1'b0 || core_slow !== 1'b0) begin
            failures++;
            $display("FAIL abort_reset got ev=%b rst=%b id=%0d instr=%b init=%b ready=%b slow=%b",
                     event_valid, core_reset, core_id, core_instr, init_done, prog_ready, core_slow);
        end
        reset = 1'b0;
        plan[5] = 2'b00;
        for (int k = 0; k < N; k++) begin
            checks++;
            if (core_id !== 4'(k) || core_reset !== 1'b1 || event_valid !== 1'b0) begin
                failures++;
                $display("FAIL reinit k=%0d got id=%0d rst=%b ev=%b", k, core_id, core_reset, event_valid);
            end
            cyc();
        end
        checks++;
        if (init_done !== 1'b1) begin
            failures++;
            $display("FAIL reinit_done got=%b want=1", init_done);
        end
        $display("abort during STEP(5) restarted init");
        // divider was cleared: slow again on the 4th sweep after reset
        sweep_count = 0;
        run_sweeps(4);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) plan[i] = 2'b00;
        test_reset();
        test_prog();
        test_slow_back_to_back();
        test_events();
        test_drop();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
